// File: rtl/core_ex_md.sv
// core_ex_md: registered execute stage with an iterative RV32M multiply/divide unit.
// The M unit and its FSM are built only when CORE_EX_MULDIV_EN is defined; otherwise M ops trap as illegal.
`timescale 1ns/1ps
module core_ex_md #(
  parameter int unsigned     XLEN              = 32,
  parameter int unsigned     MD_BITS_PER_CYCLE = 1,
  parameter logic [XLEN-1:0] CPURstAddress     = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic            flush_in,
  input  logic [XLEN-1:0] inst_addr_in,
  input  logic [6:0]      opcode_in,
  input  logic [2:0]      func3_in,
  input  logic [6:0]      func7_in,
  input  logic            reg_we_in,
  input  logic [4:0]      reg_write_addr_in,
  input  logic [XLEN-1:0] reg1_data_in,
  input  logic [XLEN-1:0] reg2_data_in,
  input  logic [XLEN-1:0] immI_in,
  input  logic [XLEN-1:0] immB_in,
  input  logic [XLEN-1:0] immJ_in,
  input  logic [XLEN-1:0] eval_val_in,
  output logic            reg_we_out,
  output logic [4:0]      reg_write_addr_out,
  output logic [XLEN-1:0] reg_write_data_out,
  output logic            hold_flag_out,
  output logic            jump_flag_out,
  output logic [XLEN-1:0] jump_addr_out,
  output logic            illegal_inst_out
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic            is_m;
  logic            base_fire, base_we, base_jump, base_illegal, taken;
  logic [XLEN-1:0] base_data, base_jaddr;
  logic            md_wr, md_we;
  logic [4:0]      md_rd;
  logic [XLEN-1:0] md_result;

  assign is_m = (opcode_in == OPC_OP) && (func7_in == 7'b0000001);

  always_comb begin
    base_we      = 1'b0;
    base_data    = eval_val_in;
    base_jump    = 1'b0;
    base_jaddr   = inst_addr_in + immB_in;
    base_illegal = 1'b0;
    taken        = 1'b0;
    unique case (opcode_in)
      OPC_OP: begin
`ifdef CORE_EX_MULDIV_EN
        base_we = reg_we_in;
`else
        base_we      = reg_we_in && !is_m;
        base_illegal = is_m;
`endif
      end
      OPC_OP_IMM, OPC_LUI, OPC_AUIPC: base_we = reg_we_in;
      OPC_JAL: begin
        base_we    = reg_we_in;
        base_data  = inst_addr_in + XLEN'(4);
        base_jump  = 1'b1;
        base_jaddr = inst_addr_in + immJ_in;
      end
      OPC_JALR: begin
        base_we    = reg_we_in;
        base_data  = inst_addr_in + XLEN'(4);
        base_jump  = 1'b1;
        base_jaddr = (reg1_data_in + immI_in) & ~XLEN'(1);
      end
      OPC_BRANCH: begin
        unique case (func3_in)
          3'b000:  taken = (reg1_data_in == reg2_data_in);
          3'b001:  taken = (reg1_data_in != reg2_data_in);
          3'b100:  taken = ($signed(reg1_data_in) <  $signed(reg2_data_in));
          3'b101:  taken = ($signed(reg1_data_in) >= $signed(reg2_data_in));
          3'b110:  taken = (reg1_data_in <  reg2_data_in);
          3'b111:  taken = (reg1_data_in >= reg2_data_in);
          default: taken = 1'b0;
        endcase
        base_jump = taken;
      end
      default: base_illegal = 1'b1;
    endcase
  end

`ifdef CORE_EX_MULDIV_EN
  localparam int unsigned STEPS = XLEN / MD_BITS_PER_CYCLE;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt;
  logic [XLEN-1:0]     opa, opb, opa_n, opb_n;
  logic [2*XLEN-1:0]   acc, acc_n, prod;
  logic [XLEN:0]       rem_t;
  logic [XLEN-1:0]     quo, rmd;
  logic [2:0]          md_f3;
  logic                md_special, neg_main, neg_rem;
  logic                a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf, special;
  logic [XLEN-1:0]     special_val, mag_a, mag_b;

  assign base_fire = valid_in && !flush_in && (state == IDLE) && !is_m;
  assign md_wr     = (state == DONE) && !flush_in;

  // Plain MUL is computed unsigned: its low half is sign-independent.
  always_comb begin
    a_sgn    = (func3_in == 3'd1) || (func3_in == 3'd2) || (func3_in == 3'd4) || (func3_in == 3'd6);
    b_sgn    = (func3_in == 3'd1) || (func3_in == 3'd4) || (func3_in == 3'd6);
    a_neg    = a_sgn && reg1_data_in[XLEN-1];
    b_neg    = b_sgn && reg2_data_in[XLEN-1];
    mag_a    = a_neg ? -reg1_data_in : reg1_data_in;
    mag_b    = b_neg ? -reg2_data_in : reg2_data_in;
    div_zero = func3_in[2] && (reg2_data_in == '0);
    div_ovf  = func3_in[2] && !func3_in[0] && (reg2_data_in == '1) &&
               (reg1_data_in == {1'b1, {(XLEN-1){1'b0}}});
    special  = div_zero || div_ovf;
    if (div_zero) special_val = func3_in[1] ? reg1_data_in : '1;
    else          special_val = func3_in[1] ? '0 : reg1_data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d       = state;
    hold_flag_out = 1'b0;
    unique case (state)
      IDLE: begin
        if (valid_in && is_m) begin
          hold_flag_out = 1'b1;
          if (special)          state_d = DONE;
          else if (func3_in[2]) state_d = DIV_RUN;
          else                  state_d = MUL_RUN;
        end
      end
      MUL_RUN, DIV_RUN: begin
        hold_flag_out = 1'b1;
        if (cnt == CNT_W'(STEPS - 1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_in) state_d = IDLE;
  end

  // MUL consumes the multiplier MSB-first into a left-shifting accumulator;
  // DIV keeps the partial remainder in acc and shifts quotient bits into opa.
  always_comb begin
    acc_n = acc;
    opa_n = opa;
    opb_n = opb;
    rem_t = '0;
    for (int unsigned i = 0; i < MD_BITS_PER_CYCLE; i++) begin
      if (state == DIV_RUN) begin
        rem_t = {acc_n[XLEN-1:0], opa_n[XLEN-1]};
        opa_n = {opa_n[XLEN-2:0], 1'b0};
        if (rem_t >= {1'b0, opb_n}) begin
          rem_t    = rem_t - {1'b0, opb_n};
          opa_n[0] = 1'b1;
        end
        acc_n = {{XLEN{1'b0}}, rem_t[XLEN-1:0]};
      end else begin
        acc_n = {acc_n[2*XLEN-2:0], 1'b0} + (opb_n[XLEN-1] ? {{XLEN{1'b0}}, opa_n} : '0);
        opb_n = {opb_n[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      opa        <= '0;
      opb        <= '0;
      acc        <= '0;
      md_f3      <= '0;
      md_rd      <= '0;
      md_we      <= 1'b0;
      md_special <= 1'b0;
      neg_main   <= 1'b0;
      neg_rem    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (valid_in && is_m && !flush_in) begin
            cnt        <= '0;
            opa        <= mag_a;
            opb        <= mag_b;
            acc        <= special ? {{XLEN{1'b0}}, special_val} : '0;
            md_f3      <= func3_in;
            md_rd      <= reg_write_addr_in;
            md_we      <= reg_we_in && (reg_write_addr_in != 5'd0);
            md_special <= special;
            neg_main   <= a_neg ^ b_neg;
            neg_rem    <= a_neg;
          end
        end
        MUL_RUN, DIV_RUN: begin
          cnt <= cnt + CNT_W'(1);
          opa <= opa_n;
          opb <= opb_n;
          acc <= acc_n;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    prod = neg_main ? -acc : acc;
    quo  = neg_main ? -opa : opa;
    rmd  = neg_rem ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    if (md_special)             md_result = acc[XLEN-1:0];
    else if (md_f3[2])          md_result = md_f3[1] ? rmd : quo;
    else if (md_f3[1:0] == 2'd0) md_result = prod[XLEN-1:0];
    else                        md_result = prod[2*XLEN-1:XLEN];
  end
`else
  assign base_fire     = valid_in && !flush_in;
  assign md_wr         = 1'b0;
  assign md_we         = 1'b0;
  assign md_rd         = '0;
  assign md_result     = '0;
  assign hold_flag_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_we_out         <= 1'b0;
      reg_write_addr_out <= '0;
      reg_write_data_out <= '0;
      jump_flag_out      <= 1'b0;
      jump_addr_out      <= CPURstAddress;
      illegal_inst_out   <= 1'b0;
    end else begin
      reg_we_out       <= 1'b0;
      jump_flag_out    <= 1'b0;
      illegal_inst_out <= 1'b0;
      if (md_wr) begin
        reg_we_out         <= md_we;
        reg_write_addr_out <= md_rd;
        reg_write_data_out <= md_result;
      end else if (base_fire) begin
        reg_we_out         <= base_we && (reg_write_addr_in != 5'd0);
        reg_write_addr_out <= reg_write_addr_in;
        reg_write_data_out <= base_data;
        jump_flag_out      <= base_jump;
        illegal_inst_out   <= base_illegal;
        if (base_jump) jump_addr_out <= base_jaddr;
      end
    end
  end

endmodule

// File: tb/tb_core_ex_md.sv
// Self-checking bench for core_ex_md: directed cases plus randomized ops against an arithmetic reference model.
// M-unit checks are compiled in only when CORE_EX_MULDIV_EN is defined.
`timescale 1ns/1ps
module tb_core_ex_md;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned BPC      = 1;
  localparam int unsigned STEPS    = XLEN / BPC;
  localparam logic [31:0] RST_ADDR = 32'h0000_0200;
  localparam logic [31:0] MIN_NEG  = 32'h8000_0000;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;

`ifdef CORE_EX_MULDIV_EN
  localparam bit M_BUILT = 1'b1;
`else
  localparam bit M_BUILT = 1'b0;
`endif

  typedef struct packed {
    logic        we;
    logic [31:0] data;
    logic        jump;
    logic [31:0] jaddr;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, valid_in, flush_in, reg_we_in;
  logic [31:0] inst_addr_in, reg1_data_in, reg2_data_in, immI_in, immB_in, immJ_in, eval_val_in;
  logic [6:0]  opcode_in, func7_in;
  logic [2:0]  func3_in;
  logic [4:0]  reg_write_addr_in;
  logic        reg_we_out, hold_flag_out, jump_flag_out, illegal_inst_out;
  logic [4:0]  reg_write_addr_out;
  logic [31:0] reg_write_data_out, jump_addr_out;

  int n_checks = 0;
  int n_errors = 0;

  core_ex_md #(
    .XLEN(XLEN),
    .MD_BITS_PER_CYCLE(BPC),
    .CPURstAddress(RST_ADDR)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .flush_in(flush_in),
    .inst_addr_in(inst_addr_in), .opcode_in(opcode_in), .func3_in(func3_in), .func7_in(func7_in),
    .reg_we_in(reg_we_in), .reg_write_addr_in(reg_write_addr_in),
    .reg1_data_in(reg1_data_in), .reg2_data_in(reg2_data_in),
    .immI_in(immI_in), .immB_in(immB_in), .immJ_in(immJ_in), .eval_val_in(eval_val_in),
    .reg_we_out(reg_we_out), .reg_write_addr_out(reg_write_addr_out),
    .reg_write_data_out(reg_write_data_out), .hold_flag_out(hold_flag_out),
    .jump_flag_out(jump_flag_out), .jump_addr_out(jump_addr_out),
    .illegal_inst_out(illegal_inst_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    valid_in = 1'b0; flush_in = 1'b0; reg_we_in = 1'b0;
    opcode_in = '0; func3_in = '0; func7_in = '0; reg_write_addr_in = '0;
    inst_addr_in = '0; reg1_data_in = '0; reg2_data_in = '0;
    immI_in = '0; immB_in = '0; immJ_in = '0; eval_val_in = '0;
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic we, input logic [4:0] rd, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] pc, input logic [31:0] ii, input logic [31:0] ib,
                       input logic [31:0] ij, input logic [31:0] ev);
    valid_in = 1'b1; opcode_in = opc; func3_in = f3; func7_in = f7;
    reg_we_in = we; reg_write_addr_in = rd; reg1_data_in = r1; reg2_data_in = r2;
    inst_addr_in = pc; immI_in = ii; immB_in = ib; immJ_in = ij; eval_val_in = ev;
  endtask

  function automatic exp_t model_basic(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                       input logic we, input logic [4:0] rd, input logic [31:0] r1,
                                       input logic [31:0] r2, input logic [31:0] pc, input logic [31:0] ii,
                                       input logic [31:0] ib, input logic [31:0] ij, input logic [31:0] ev);
    exp_t e;
    bit   wr;
    int   s1, s2;
    e  = '0;
    wr = 1'b0;
    s1 = r1;
    s2 = r2;
    case (opc)
      OP: begin
        if (!M_BUILT && f7 == 7'b0000001) e.ill = 1'b1;
        else begin wr = 1'b1; e.data = ev; end
      end
      OP_IMM, LUI, AUIPC: begin wr = 1'b1; e.data = ev; end
      JAL:  begin wr = 1'b1; e.data = pc + 4; e.jump = 1'b1; e.jaddr = pc + ij; end
      JALR: begin wr = 1'b1; e.data = pc + 4; e.jump = 1'b1; e.jaddr = (r1 + ii) & 32'hFFFF_FFFE; end
      BRANCH: begin
        case (f3)
          3'd0: e.jump = (r1 == r2);
          3'd1: e.jump = (r1 != r2);
          3'd4: e.jump = (s1 < s2);
          3'd5: e.jump = (s1 >= s2);
          3'd6: e.jump = (r1 < r2);
          3'd7: e.jump = (r1 >= r2);
          default: e.jump = 1'b0;
        endcase
        e.jaddr = pc + ib;
      end
      default: e.ill = 1'b1;
    endcase
    e.we = wr && we && (rd != 0);
    return e;
  endfunction

  task automatic run_basic(input string tag, input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                           input logic we, input logic [4:0] rd, input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] pc, input logic [31:0] ii, input logic [31:0] ib,
                           input logic [31:0] ij, input logic [31:0] ev);
    exp_t e;
    e = model_basic(opc, f3, f7, we, rd, r1, r2, pc, ii, ib, ij, ev);
    drive(opc, f3, f7, we, rd, r1, r2, pc, ii, ib, ij, ev);
    @(negedge clk);
    check({tag, "_hold"}, hold_flag_out, 1'b0);
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(negedge clk);
    check({tag, "_we"}, reg_we_out, e.we);
    if (e.we) begin
      check({tag, "_rd"}, reg_write_addr_out, rd);
      check({tag, "_wdata"}, reg_write_data_out, e.data);
    end
    check({tag, "_jump"}, jump_flag_out, e.jump);
    if (e.jump) check({tag, "_jaddr"}, jump_addr_out, e.jaddr);
    check({tag, "_illegal"}, illegal_inst_out, e.ill);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_pulse_clear"}, {reg_we_out, jump_flag_out, illegal_inst_out}, 3'b000);
    @(posedge clk); #1;
  endtask

`ifdef CORE_EX_MULDIV_EN
  function automatic logic [31:0] model_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    int ia, ib;
    if (!f3[2]) begin
      sa = (f3 == 3'd1 || f3 == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
      sb = (f3 == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
      p  = sa * sb;
      return (f3 == 3'd0) ? p[31:0] : p[63:32];
    end
    if (b == 0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0] && a == MIN_NEG && b == 32'hFFFF_FFFF) return f3[1] ? 32'h0 : a;
    if (!f3[0]) begin
      ia = a;
      ib = b;
      return f3[1] ? ia % ib : ia / ib;
    end
    return f3[1] ? a % b : a / b;
  endfunction

  task automatic run_m(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    logic [31:0] exp;
    bit          special, seen;
    int          hc, early;
    exp     = model_m(f3, a, b);
    special = f3[2] && (b == 0 || (!f3[0] && a == MIN_NEG && b == 32'hFFFF_FFFF));
    drive(OP, f3, 7'b0000001, 1'b1, rd, a, b, $urandom, $urandom, $urandom, $urandom, $urandom);
    hc = 0; early = 0; seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (reg_we_out) early++;
      if (hold_flag_out) hc++;
      else seen = 1'b1;
      if (!seen) begin @(posedge clk); #1; end
    end
    valid_in = 1'b0;
    check({tag, "_done_seen"}, seen, 1'b1);
    check({tag, "_hold_cycles"}, hc, special ? 1 : STEPS + 1);
    check({tag, "_early_write"}, early, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_we"}, reg_we_out, 1'b1);
    check({tag, "_rd"}, reg_write_addr_out, rd);
    check({tag, "_wdata"}, reg_write_data_out, exp);
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected simulation to complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0]  opcs [8];
    logic [6:0]  f7s  [3];
    logic [2:0]  brf3 [6];
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] r1, r2;
    int          wr;

    opcs = '{OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, 7'b0000000};
    f7s  = '{7'h00, 7'h20, 7'h01};
    brf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

    set_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_we", reg_we_out, 1'b0);
    check("rst_rd", reg_write_addr_out, 5'd0);
    check("rst_wdata", reg_write_data_out, 32'h0);
    check("rst_jump", jump_flag_out, 1'b0);
    check("rst_jaddr", jump_addr_out, RST_ADDR);
    check("rst_illegal", illegal_inst_out, 1'b0);
    check("rst_hold", hold_flag_out, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_basic("addi", OP_IMM, 3'd0, 7'h00, 1'b1, 5'd3, 32'h0, 32'h0, 32'h0, 32'h5, 32'h0, 32'h0, 32'h5);
    run_basic("blt", BRANCH, 3'd4, 7'h00, 1'b1, 5'd9, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h0, 32'h20, 32'h0, 32'h77);
    run_basic("bltu", BRANCH, 3'd6, 7'h00, 1'b1, 5'd9, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h0, 32'h20, 32'h0, 32'h77);
    run_basic("jal", JAL, 3'd0, 7'h00, 1'b1, 5'd1, 32'h0, 32'h0, 32'h400, 32'h0, 32'h0, 32'hFFFF_FFF0, 32'h0);
    run_basic("jalr", JALR, 3'd0, 7'h00, 1'b1, 5'd2, 32'h1003, 32'h0, 32'h80, 32'h4, 32'h0, 32'h0, 32'h0);
    run_basic("rd0", OP, 3'd0, 7'h00, 1'b1, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1234);
    run_basic("unknown", 7'b1111111, 3'd0, 7'h00, 1'b1, 5'd4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h9);

`ifdef CORE_EX_MULDIV_EN
    run_m("mul", 3'd0, 32'hFFFF_FFFF, 32'h2, 5'd5);
    run_m("mulhu", 3'd3, 32'hFFFF_FFFF, 32'h2, 5'd6);
    run_m("div_by0", 3'd4, 32'd7, 32'h0, 5'd7);
    run_m("rem_ovf", 3'd6, MIN_NEG, 32'hFFFF_FFFF, 5'd8);
    run_m("div_neg", 3'd4, -32'sd7, 32'd2, 5'd10);
    run_m("rem_neg", 3'd6, -32'sd7, 32'd2, 5'd11);

    // DIVU killed mid-iteration: no writeback may ever appear.
    drive(OP, 3'd5, 7'b0000001, 1'b1, 5'd12, 32'd100, 32'd7, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (4) begin @(posedge clk); #1; end
    flush_in = 1'b1;
    valid_in = 1'b0;
    @(posedge clk); #1;
    flush_in = 1'b0;
    @(negedge clk);
    check("flush_hold", hold_flag_out, 1'b0);
    wr = 0;
    repeat (40) begin @(posedge clk); #1; @(negedge clk); if (reg_we_out) wr++; end
    check("flush_no_write", wr, 0);
    @(posedge clk); #1;
    run_basic("add_after_flush", OP, 3'd0, 7'h00, 1'b1, 5'd13, 32'h1, 32'h2, 32'h0, 32'h0, 32'h0, 32'h0, 32'h3);

    drive(OP, 3'd0, 7'b0000001, 1'b1, 5'd14, 32'd3, 32'd5, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (3) begin @(posedge clk); #1; end
    valid_in = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_hold", hold_flag_out, 1'b0);
    check("midrst_we", reg_we_out, 1'b0);
    check("midrst_jaddr", jump_addr_out, RST_ADDR);
    wr = 0;
    repeat (40) begin @(posedge clk); #1; @(negedge clk); if (reg_we_out) wr++; end
    check("midrst_no_write", wr, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      f3 = 3'($urandom_range(7, 0));
      r1 = ($urandom_range(3, 0) == 0) ? MIN_NEG : $urandom;
      case ($urandom_range(5, 0))
        0:       r2 = 32'h0;
        1:       r2 = 32'hFFFF_FFFF;
        2:       r2 = 32'($urandom_range(15, 1));
        default: r2 = $urandom;
      endcase
      run_m($sformatf("rand_m%0d_f3_%0d", i, f3), f3, r1, r2, 5'($urandom_range(31, 1)));
    end
`else
    run_basic("mul_disabled", OP, 3'd0, 7'b0000001, 1'b1, 5'd5, 32'hFFFF_FFFF, 32'h2,
              32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 8; i++)
      run_basic($sformatf("rand_mdis%0d", i), OP, 3'($urandom_range(7, 0)), 7'b0000001, 1'b1,
                5'($urandom_range(31, 1)), $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
`endif

    for (int i = 0; i < 50; i++) begin
      opc = opcs[$urandom_range(7, 0)];
      f3  = (opc == BRANCH) ? brf3[$urandom_range(5, 0)] : 3'($urandom_range(7, 0));
      f7  = (opc == OP) ? f7s[$urandom_range(M_BUILT ? 1 : 2, 0)] : 7'h00;
      r1  = $urandom;
      r2  = ($urandom_range(3, 0) == 0) ? r1 : $urandom;
      run_basic($sformatf("rand%0d_op%0h", i, opc), opc, f3, f7, ($urandom_range(3, 0) != 0),
                5'($urandom_range(31, 0)), r1, r2, $urandom, $urandom, $urandom, $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
